// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter sequencer.
//   state_e   - sequencer FSM states
//   mode_e    - counting modes (register value 3 decodes to WRAP)
//   dir_e     - bounce direction
//   ADDR_*    - config register addresses
//   *_RST     - reset defaults (LIMIT resets to all-ones of the datapath width)
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_BOUNCE  = 2'd2
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [1:0] ADDR_START = 2'd0;
  localparam logic [1:0] ADDR_LIMIT = 2'd1;
  localparam logic [1:0] ADDR_STEP  = 2'd2;
  localparam logic [1:0] ADDR_MODE  = 2'd3;

  localparam int unsigned START_RST = 0;
  localparam int unsigned STEP_RST  = 1;
  localparam mode_e       MODE_RST  = MODE_WRAP;
  localparam dir_e        DIR_RST   = DIR_UP;

  // Raw MODE field to mode; the spare encoding 3 behaves as WRAP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_ONESHOT;
      2'd2:    return MODE_BOUNCE;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: register-write handshake into the counter sequencer.
//   cfg_valid - write request (master)
//   cfg_ready - write accepted when high together with cfg_valid (slave)
//   cfg_addr  - register select: START, LIMIT, STEP, MODE
//   cfg_data  - write data, WIDTH bits
// WIDTH must match the WIDTH of the counter_sequencer it is connected to.
interface counter_sequencer_if #(
  parameter int WIDTH = 8
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_addr;
  logic [WIDTH-1:0] cfg_data;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    output cfg_ready
  );

endinterface

// File: rtl/counter_step.sv
// counter_step: purely combinational next-count computation for one RUN cycle.
//   count_i/step_i/start_i/limit_i - current count and configuration
//   mode_i, dir_i                  - counting mode and current bounce direction
//   next_o      - count after this step
//   wrap_hit_o  - WRAP mode reloaded START this step
//   limit_hit_o - ONESHOT mode reached LIMIT this step
//   dir_next_o  - bounce direction after this step
// Sums and differences carry one extra bit so results clamp to LIMIT/START
// instead of silently overflowing the WIDTH-bit count.
module counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] start_i,
  input  logic [WIDTH-1:0] limit_i,
  input  mode_e            mode_i,
  input  dir_e             dir_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_hit_o,
  output logic             limit_hit_o,
  output dir_e             dir_next_o
);

  logic [WIDTH-1:0] eff_step;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   down_diff;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_val;

  // A zero step would stall the counter forever, so it counts as one.
  assign eff_step  = (step_i == '0) ? WIDTH'(1) : step_i;
  assign up_sum    = {1'b0, count_i} + {1'b0, eff_step};
  assign down_diff = {1'b0, count_i} - {1'b0, eff_step};

  // Borrow out of the extra bit means the subtraction went below zero.
  assign up_val   = (up_sum > {1'b0, limit_i}) ? limit_i : up_sum[WIDTH-1:0];
  assign down_val = (down_diff[WIDTH] || (down_diff[WIDTH-1:0] < start_i))
                    ? start_i : down_diff[WIDTH-1:0];

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    next_o      = up_val;
    wrap_hit_o  = 1'b0;
    limit_hit_o = 1'b0;
    dir_next_o  = dir_i;
    case (mode_i)
      MODE_ONESHOT: begin
        limit_hit_o = (up_val == limit_i);
      end
      MODE_BOUNCE: begin
        // Turn around first, then step in the new direction.
        if (dir_i == DIR_UP && count_i == limit_i) begin
          dir_next_o = DIR_DOWN;
        end else if (dir_i == DIR_DOWN && count_i == start_i) begin
          dir_next_o = DIR_UP;
        end
        next_o = (dir_next_o == DIR_DOWN) ? down_val : up_val;
      end
      default: begin
        if (count_i == limit_i) begin
          next_o     = start_i;
          wrap_hit_o = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: programmable controller owning the count register.
//   clk, rst_n            - clock, asynchronous active-low reset
//   cfg                   - register-write handshake (slave side)
//   cmd_start/stop/abort  - run control; same-cycle priority abort > stop > start
//   count                 - current count (registered)
//   busy                  - state is RUN or PAUSE
//   wrap                  - one-cycle pulse when WRAP mode reloads START
//   done                  - one-cycle pulse on entry to DONE
//   err                   - sticky: start refused with START > LIMIT; cleared by
//                           the next accepted write
// Reset defaults (START 0, LIMIT all-ones, STEP 1, WRAP) give a free-running
// counter over the full range.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_sequencer_if.slave cfg,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  dir_e             dir_q;
  logic             busy_q;
  logic             wrap_q;
  logic             done_q;
  logic             err_q;

  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] step_q;
  mode_e            mode_q;

  logic [WIDTH-1:0] count_d;
  dir_e             dir_d;
  logic             wrap_hit;
  logic             limit_hit;

  logic             cfg_accept;
  logic             start_ok;
  logic             launch;

  // Writes are only taken while stopped so configuration never changes under
  // a running count; this is the sole output that is not registered.
  assign cfg.cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cfg_accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign start_ok      = (start_q <= limit_q);
  // stop outranks start, so a start accompanied by stop does nothing.
  assign launch        = cmd_start && !cmd_stop;

  counter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .count_i    (count_q),
    .step_i     (step_q),
    .start_i    (start_q),
    .limit_i    (limit_q),
    .mode_i     (mode_q),
    .dir_i      (dir_q),
    .next_o     (count_d),
    .wrap_hit_o (wrap_hit),
    .limit_hit_o(limit_hit),
    .dir_next_o (dir_d)
  );

  // Configuration registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= WIDTH'(START_RST);
      limit_q <= '1;
      step_q  <= WIDTH'(STEP_RST);
      mode_q  <= MODE_RST;
    end else if (cfg_accept) begin
      case (cfg.cfg_addr)
        ADDR_START: start_q <= cfg.cfg_data;
        ADDR_LIMIT: limit_q <= cfg.cfg_data;
        ADDR_STEP:  step_q  <= cfg.cfg_data;
        ADDR_MODE:  mode_q  <= decode_mode(cfg.cfg_data[1:0]);
        default:    ;
      endcase
    end
  end

  // Sequencer FSM with registered outputs; busy is written alongside each
  // state change so it already reflects the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= DIR_RST;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      // A refused start later in this block overrides the clear.
      if (cfg_accept) begin
        err_q <= 1'b0;
      end

      if (cmd_abort) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        dir_q   <= DIR_UP;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (launch) begin
              if (start_ok) begin
                state_q <= ST_RUN;
                count_q <= start_q;
                dir_q   <= DIR_UP;
                busy_q  <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (cmd_stop) begin
              state_q <= ST_PAUSE;
            end else begin
              count_q <= count_d;
              dir_q   <= dir_d;
              wrap_q  <= wrap_hit;
              if (limit_hit) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          ST_PAUSE: begin
            // Resume from the held count; the next step lands one cycle later.
            if (launch) begin
              state_q <= ST_RUN;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed self-checking bench for counter_sequencer.
// Expected per-cycle outputs are pushed to a scoreboard queue as stimulus is
// driven, then popped and compared once per cycle on the falling clock edge.
module tb_counter_sequencer;
  import counter_pkg::*;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             cmd_start = 1'b0;
  logic             cmd_stop  = 1'b0;
  logic             cmd_abort = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             wrap;
  logic             done;
  logic             err;

  int passes = 0;
  int total  = 0;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             done;
    logic             busy;
  } exp_t;

  exp_t sb_q[$];

  counter_sequencer_if #(.WIDTH(WIDTH)) cfg_if ();

  counter_sequencer #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .cmd_abort(cmd_abort),
    .count    (count),
    .busy     (busy),
    .wrap     (wrap),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input logic [WIDTH-1:0] c, input logic w, input logic d, input logic b);
    exp_t e;
    e.count = c;
    e.wrap  = w;
    e.done  = d;
    e.busy  = b;
    sb_q.push_back(e);
  endtask

  // Compare the current cycle against the oldest entry, advancing one cycle
  // between entries; returns on the cycle of the last entry.
  task automatic drain(input string tag);
    exp_t e;
    int   idx = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s[%0d].count", tag, idx), 32'(count), 32'(e.count));
      check($sformatf("%s[%0d].wrap", tag, idx), 32'(wrap), 32'(e.wrap));
      check($sformatf("%s[%0d].done", tag, idx), 32'(done), 32'(e.done));
      check($sformatf("%s[%0d].busy", tag, idx), 32'(busy), 32'(e.busy));
      if (sb_q.size() > 0) @(negedge clk);
      idx++;
    end
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [WIDTH-1:0] data);
    check("cfg_ready_idle", 32'(cfg_if.cfg_ready), 32'd1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_data  = data;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic do_abort(input string tag);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check({tag, ".count"}, 32'(count), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_addr  = 2'd0;
    cfg_if.cfg_data  = '0;

    // Reset values.
    @(negedge clk);
    check("rst.count", 32'(count), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.wrap", 32'(wrap), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Defaults: free-running 0..255 then wrap back to 0.
    pulse_start();
    for (int i = 0; i < 256; i++) push(WIDTH'(i), 1'b0, 1'b0, 1'b1);
    push(8'd0, 1'b1, 1'b0, 1'b1);
    drain("dflt");
    do_abort("dflt_abort");

    // WRAP with clamp to LIMIT before reload.
    cfg_write(ADDR_START, 8'd10);
    cfg_write(ADDR_LIMIT, 8'd20);
    cfg_write(ADDR_STEP, 8'd3);
    cfg_write(ADDR_MODE, 8'd0);
    pulse_start();
    push(8'd10, 1'b0, 1'b0, 1'b1);
    push(8'd13, 1'b0, 1'b0, 1'b1);
    push(8'd16, 1'b0, 1'b0, 1'b1);
    push(8'd19, 1'b0, 1'b0, 1'b1);
    push(8'd20, 1'b0, 1'b0, 1'b1);
    push(8'd10, 1'b1, 1'b0, 1'b1);
    push(8'd13, 1'b0, 1'b0, 1'b1);
    drain("wrap");
    do_abort("wrap_abort");

    // ONESHOT: clamp on the last step, done pulse, then hold in DONE.
    cfg_write(ADDR_START, 8'd0);
    cfg_write(ADDR_LIMIT, 8'd7);
    cfg_write(ADDR_STEP, 8'd2);
    cfg_write(ADDR_MODE, 8'd1);
    pulse_start();
    push(8'd0, 1'b0, 1'b0, 1'b1);
    push(8'd2, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    push(8'd6, 1'b0, 1'b0, 1'b1);
    push(8'd7, 1'b0, 1'b1, 1'b0);
    push(8'd7, 1'b0, 1'b0, 1'b0);
    push(8'd7, 1'b0, 1'b0, 1'b0);
    drain("oneshot");
    check("oneshot.cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    pulse_start();
    check("oneshot.restart.count", 32'(count), 32'd0);
    check("oneshot.restart.busy", 32'(busy), 32'd1);
    do_abort("oneshot_abort");

    // BOUNCE with a pause in the middle.
    cfg_write(ADDR_START, 8'd2);
    cfg_write(ADDR_LIMIT, 8'd5);
    cfg_write(ADDR_STEP, 8'd1);
    cfg_write(ADDR_MODE, 8'd2);
    pulse_start();
    push(8'd2, 1'b0, 1'b0, 1'b1);
    push(8'd3, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    push(8'd5, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    push(8'd3, 1'b0, 1'b0, 1'b1);
    push(8'd2, 1'b0, 1'b0, 1'b1);
    push(8'd3, 1'b0, 1'b0, 1'b1);
    drain("bounce");
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    check("pause1.count", 32'(count), 32'd3);
    check("pause1.busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("pause2.count", 32'(count), 32'd3);
    pulse_start();
    push(8'd3, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    push(8'd5, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    drain("resume");

    // Write attempt during RUN plus all three commands at count 4.
    check("run.cfg_ready", 32'(cfg_if.cfg_ready), 32'd0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = ADDR_LIMIT;
    cfg_if.cfg_data  = 8'd9;
    cmd_abort = 1'b1;
    cmd_stop  = 1'b1;
    cmd_start = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    cmd_abort = 1'b0;
    cmd_stop  = 1'b0;
    cmd_start = 1'b0;
    check("allcmd.count", 32'(count), 32'd0);
    check("allcmd.busy", 32'(busy), 32'd0);
    check("allcmd.cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    // LIMIT must still be 5: the bounce turns at 5, not 9.
    pulse_start();
    push(8'd2, 1'b0, 1'b0, 1'b1);
    push(8'd3, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    push(8'd5, 1'b0, 1'b0, 1'b1);
    push(8'd4, 1'b0, 1'b0, 1'b1);
    drain("limit_kept");
    do_abort("bounce_abort");

    // START > LIMIT refuses the start and sets err; next write clears it.
    cfg_write(ADDR_START, 8'd9);
    cfg_write(ADDR_LIMIT, 8'd3);
    pulse_start();
    check("badstart.err", 32'(err), 32'd1);
    check("badstart.busy", 32'(busy), 32'd0);
    check("badstart.count", 32'(count), 32'd0);
    @(negedge clk);
    check("badstart.err_sticky", 32'(err), 32'd1);
    cfg_write(ADDR_MODE, 8'd0);
    check("err_cleared", 32'(err), 32'd0);

    // Asynchronous reset mid-RUN at count 0x40.
    cfg_write(ADDR_START, 8'h10);
    cfg_write(ADDR_LIMIT, 8'hF0);
    cfg_write(ADDR_STEP, 8'd1);
    pulse_start();
    check("arst.first", 32'(count), 32'h10);
    repeat (8'h30) @(negedge clk);
    check("arst.before", 32'(count), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("arst.count", 32'(count), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.wrap", 32'(wrap), 32'd0);
    check("arst.done", 32'(done), 32'd0);
    check("arst.err", 32'(err), 32'd0);
    check("arst.cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Config registers back at defaults: counting restarts from 0 by 1.
    pulse_start();
    push(8'd0, 1'b0, 1'b0, 1'b1);
    push(8'd1, 1'b0, 1'b0, 1'b1);
    push(8'd2, 1'b0, 1'b0, 1'b1);
    drain("post_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
